// File: rtl/thr_int_timeout_mon_if.sv
// Interrupt-timeout monitor bus: interrupt strobes and thread status in,
// per-thread wait/error status out.
interface thr_int_timeout_mon_if #(
  parameter int NUM_THR = 4,
  parameter int CNT_W   = 16
);
  logic               mon_en;
  logic               nukeint;
  logic               resumint;
  logic               rstint;
  logic [NUM_THR-1:0] rstthr;
  logic [NUM_THR-1:0] thr_dead;
  logic [CNT_W-1:0]   max_wait;
  logic [NUM_THR-1:0] pend;
  logic [NUM_THR-1:0] err_vec;
  logic [NUM_THR-1:0] err_type;
  logic [7:0]         err_cnt;
  logic               err_sticky;

  modport master (
    output mon_en,
    output nukeint,
    output resumint,
    output rstint,
    output rstthr,
    output thr_dead,
    output max_wait,
    input  pend,
    input  err_vec,
    input  err_type,
    input  err_cnt,
    input  err_sticky
  );

  modport slave (
    input  mon_en,
    input  nukeint,
    input  resumint,
    input  rstint,
    input  rstthr,
    input  thr_dead,
    input  max_wait,
    output pend,
    output err_vec,
    output err_type,
    output err_cnt,
    output err_sticky
  );
endinterface

// File: rtl/thr_int_timeout_mon.sv
// Per-thread interrupt wait timeout monitor with error pulse/count/sticky.
// Define THR_INT_MON_RESUME_CHK_EN to also watch resumes (RES_WAIT).
module thr_int_timeout_mon #(
  parameter int NUM_THR = 4,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  thr_int_timeout_mon_if.slave  bus
);

`ifdef THR_INT_MON_RESUME_CHK_EN
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    NUKE_WAIT = 2'd1,
    RES_WAIT  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    NUKE_WAIT = 2'd1
  } state_e;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q [NUM_THR];
  state_e             state_d [NUM_THR];
  logic [CNT_W-1:0]   cnt_q   [NUM_THR];
  logic [CNT_W-1:0]   cnt_d   [NUM_THR];

  logic [NUM_THR-1:0] tgt;
  logic [NUM_THR-1:0] to_vec;
  logic [NUM_THR-1:0] pend_w;
  logic [NUM_THR-1:0] err_vec_q;
  logic [7:0]         err_cnt_q;
  logic               sticky_q;
  logic [5:0]         to_pop;
  logic [8:0]         cnt_sum;
  logic [7:0]         cnt_sat;

`ifdef THR_INT_MON_RESUME_CHK_EN
  logic [NUM_THR-1:0] to_res;
  logic [NUM_THR-1:0] err_type_q;
`endif

  function automatic logic [5:0] popcnt(
    input logic [NUM_THR-1:0] v
  );
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < NUM_THR; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  // Isolate the lowest set bit: only that thread is targeted.
  assign tgt = bus.rstthr & (~bus.rstthr + NUM_THR'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_vec  = '0;
`ifdef THR_INT_MON_RESUME_CHK_EN
    to_res  = '0;
`endif
    for (int i = 0; i < NUM_THR; i++) begin
      unique case (state_q[i])
        NUKE_WAIT: begin
          if (bus.thr_dead[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= bus.max_wait) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            to_vec[i]  = 1'b1;
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
`ifdef THR_INT_MON_RESUME_CHK_EN
        RES_WAIT: begin
          if (!bus.thr_dead[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= bus.max_wait) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            to_vec[i]  = 1'b1;
            to_res[i]  = 1'b1;
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
`endif
        default: ;
      endcase

      // Events land on top of this cycle's evaluation.
      if (tgt[i]) begin
        priority case (1'b1)
          bus.rstint: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
          bus.resumint: begin
`ifdef THR_INT_MON_RESUME_CHK_EN
            state_d[i] = RES_WAIT;
`else
            state_d[i] = IDLE;
`endif
            cnt_d[i]   = '0;
          end
          bus.nukeint: begin
            if (state_d[i] != NUKE_WAIT) begin
              state_d[i] = NUKE_WAIT;
              cnt_d[i]   = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign to_pop  = popcnt(to_vec);
  assign cnt_sum = {1'b0, err_cnt_q} + {3'd0, to_pop};
  assign cnt_sat = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_THR; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      err_vec_q <= '0;
      err_cnt_q <= '0;
      sticky_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bus.mon_en) begin
        err_vec_q <= to_vec;
        err_cnt_q <= cnt_sat;
        if (|to_vec) begin
          sticky_q <= 1'b1;
        end
      end else begin
        err_vec_q <= '0;
      end
    end
  end

`ifdef THR_INT_MON_RESUME_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_type_q <= '0;
    end else if (bus.mon_en) begin
      err_type_q <= to_vec & to_res;
    end else begin
      err_type_q <= '0;
    end
  end

  assign bus.err_type = err_type_q;
`else
  assign bus.err_type = '0;
`endif

  always_comb begin
    pend_w = '0;
    for (int i = 0; i < NUM_THR; i++) begin
      pend_w[i] = (state_q[i] != IDLE);
    end
  end

  assign bus.pend       = pend_w;
  assign bus.err_vec    = err_vec_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_thr_int_timeout_mon.sv
// Bench for thr_int_timeout_mon: vector table, corner sequences,
// then random traffic against a timestamp-based reference model.
module tb_thr_int_timeout_mon;
  localparam int N = 4;
  localparam int W = 16;
`ifdef THR_INT_MON_RESUME_CHK_EN
  localparam bit RES_EN = 1'b1;
`else
  localparam bit RES_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  thr_int_timeout_mon_if #(.NUM_THR(N), .CNT_W(W)) bus ();

  thr_int_timeout_mon #(.NUM_THR(N), .CNT_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: wait kind (0 none, 1 nuke, 2 resume) and the
  // edge index at which the wait began.
  int           kind  [N];
  int           start [N];
  int           cyc;
  int           m_cnt;
  bit           m_sticky;
  logic [N-1:0] m_vec;
  logic [N-1:0] m_type;

  typedef struct {
    logic         nk;
    logic         rs;
    logic         ri;
    logic [N-1:0] thr;
    logic [N-1:0] dead;
    logic [W-1:0] mw;
    logic         en;
    logic [N-1:0] e_pend;
    logic [N-1:0] e_vec;
    int           e_cnt;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      kind[i]  = 0;
      start[i] = 0;
    end
    m_cnt    = 0;
    m_sticky = 1'b0;
    m_vec    = '0;
    m_type   = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] to;
    logic [N-1:0] ty;
    int           tg;
    bit           ok;
    to = '0;
    ty = '0;
    tg = -1;
    for (int i = 0; i < N; i++) begin
      if (kind[i] != 0) begin
        ok = (kind[i] == 1) ? bus.thr_dead[i] : !bus.thr_dead[i];
        if (ok) begin
          kind[i] = 0;
        end else if (cyc - start[i] - 1 >= int'(bus.max_wait)) begin
          to[i]   = 1'b1;
          ty[i]   = (kind[i] == 2);
          kind[i] = 0;
        end
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.rstthr[i]) tg = i;
    end
    if (tg >= 0) begin
      if (bus.rstint) begin
        kind[tg] = 0;
      end else if (bus.resumint) begin
        kind[tg]  = RES_EN ? 2 : 0;
        start[tg] = cyc;
      end else if (bus.nukeint && kind[tg] != 1) begin
        kind[tg]  = 1;
        start[tg] = cyc;
      end
    end
    if (bus.mon_en) begin
      m_vec  = to;
      m_type = ty;
      m_cnt  = m_cnt + $countones(to);
      if (m_cnt > 255) m_cnt = 255;
      if (to != '0) m_sticky = 1'b1;
    end else begin
      m_vec  = '0;
      m_type = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_clear();
    else model_step();
  endtask

  task automatic drive(input logic nk, input logic rs,
                       input logic ri, input logic [N-1:0] thr,
                       input logic [N-1:0] dead,
                       input logic [W-1:0] mw, input logic en);
    bus.nukeint  = nk;
    bus.resumint = rs;
    bus.rstint   = ri;
    bus.rstthr   = thr;
    bus.thr_dead = dead;
    bus.max_wait = mw;
    bus.mon_en   = en;
  endtask

  task automatic idle(input logic [W-1:0] mw);
    drive(1'b0, 1'b0, 1'b0, '0, '0, mw, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'b0001, '0, 16'd0, 1'b1);
    tick();
    tick();
    chk("rst.pend", bus.pend, 0);
    chk("rst.vec", bus.err_vec, 0);
    chk("rst.type", bus.err_type, 0);
    chk("rst.cnt", bus.err_cnt, 0);
    chk("rst.sticky", bus.err_sticky, 0);
    idle(16'd0);
    rst = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    logic [N-1:0] mp;
    for (int i = 0; i < N; i++) mp[i] = (kind[i] != 0);
    chk({tag, ".pend"}, bus.pend, mp);
    chk({tag, ".vec"}, bus.err_vec, m_vec);
    chk({tag, ".type"}, bus.err_type, m_type);
    chk({tag, ".cnt"}, bus.err_cnt, m_cnt);
    chk({tag, ".sticky"}, bus.err_sticky, m_sticky);
  endtask

  initial begin
    logic [N-1:0] acc;
    int           first;
    int           pulses;
    logic         tseen;
    int           ecnt;

    cyc = 0;
    model_clear();
    rst = 1'b1;
    idle(16'd0);

    // ---- table of single-cycle vectors, outputs after each edge
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 16'd1, 1'b1,
                4'b0001, 4'b0000, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd1, 1'b1,
                4'b0001, 4'b0000, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd1, 1'b1,
                4'b0000, 4'b0001, 1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'b1100, 4'b0000, 16'd1, 1'b1,
                4'b0100, 4'b0000, 1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000, 16'd1, 1'b1,
                4'b0000, 4'b0000, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd1, 1'b1,
                4'b0000, 4'b0000, 1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000, 16'd0, 1'b1,
                4'b1000, 4'b0000, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 16'd0, 1'b1,
                4'b0000, 4'b0000, 1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 16'd0, 1'b1,
                4'b0010, 4'b0000, 1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd0, 1'b1,
                4'b0000, 4'b0010, 2};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4'b0010, 4'b0000, 16'd0, 1'b1,
                (RES_EN ? 4'b0010 : 4'b0000), 4'b0000, 2};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd0, 1'b1,
                4'b0000, 4'b0000, 2};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 16'd0, 1'b0,
                4'b0001, 4'b0000, 2};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd0, 1'b0,
                4'b0000, 4'b0000, 2};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 16'd5, 1'b1,
                4'b0001, 4'b0000, 2};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 16'd1, 1'b1,
                4'b0001, 4'b0000, 2};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd1, 1'b1,
                4'b0000, 4'b0001, 3};

    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].nk, tbl[k].rs, tbl[k].ri, tbl[k].thr,
            tbl[k].dead, tbl[k].mw, tbl[k].en);
      tick();
      chk($sformatf("tbl%0d.pend", k), bus.pend, tbl[k].e_pend);
      chk($sformatf("tbl%0d.vec", k), bus.err_vec, tbl[k].e_vec);
      chk($sformatf("tbl%0d.type", k), bus.err_type, 0);
      chk($sformatf("tbl%0d.cnt", k), bus.err_cnt, tbl[k].e_cnt);
      chk($sformatf("tbl%0d.sticky", k), bus.err_sticky,
          (tbl[k].e_cnt != 0));
    end

    // ---- dead flag resolves a nuke wait
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'b0010, '0, 16'd10, 1'b1);
    tick();
    idle(16'd10);
    acc = '0;
    for (int k = 1; k <= 15; k++) begin
      if (k >= 6) bus.thr_dead = 4'b0010;
      tick();
      acc = acc | bus.err_vec;
      if (k == 5) chk("dead.pend5", bus.pend, 4'b0010);
      if (k == 6) chk("dead.pend6", bus.pend, 4'b0000);
    end
    chk("dead.noerr", acc, 0);

    // ---- timeout latency and single-cycle pulse
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'b1000, '0, 16'd10, 1'b1);
    tick();
    idle(16'd10);
    first  = -1;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.err_vec != '0) begin
        pulses++;
        if (first < 0) first = k;
        chk("to.vec", bus.err_vec, 4'b1000);
      end
    end
    chk("to.latency", first, 11);
    chk("to.pulses", pulses, 1);
    chk("to.cnt", bus.err_cnt, 1);
    chk("to.sticky", bus.err_sticky, 1);

    // ---- nuke and resume to the same target
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 4'b0110, '0, 16'd2, 1'b1);
    tick();
    chk("nr.pend", bus.pend, RES_EN ? 4'b0010 : 4'b0000);
    idle(16'd2);
    tick();
    chk("nr.pend2", bus.pend, 0);
    chk("nr.vec", bus.err_vec, 0);
    chk("nr.cnt", bus.err_cnt, 0);

    // ---- simultaneous timeouts and saturation
    do_reset();
    ecnt = 0;
    for (int r = 0; r < 150; r++) begin
      drive(1'b1, 1'b0, 1'b0, 4'b0001, '0, 16'd3, 1'b1);
      tick();
      drive(1'b1, 1'b0, 1'b0, 4'b0100, '0, 16'd3, 1'b1);
      tick();
      idle(16'd3);
      tick();
      tick();
      if (r == 0) chk("dual.pre", bus.err_vec, 0);
      idle(16'd2);
      tick();
      ecnt = (ecnt + 2 > 255) ? 255 : ecnt + 2;
      chk("dual.vec", bus.err_vec, 4'b0101);
      chk("dual.cnt", bus.err_cnt, ecnt);
      idle(16'd3);
      tick();
      if (r == 0 || r == 149) chk("dual.post", bus.err_vec, 0);
    end
    chk("sat.cnt", bus.err_cnt, 255);

    // ---- resume with the thread held dead
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001, 16'd4, 1'b1);
    tick();
    bus.resumint = 1'b0;
    bus.rstthr   = '0;
    pulses = 0;
    tseen  = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.err_vec[0]) begin
        pulses++;
        tseen = bus.err_type[0];
        chk("res.at5", k, 5);
      end
    end
    chk("res.pulses", pulses, RES_EN ? 1 : 0);
    chk("res.type", tseen, RES_EN);

    // ---- async reset mid-wait, then honour first event
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'b0001, '0, 16'd5, 1'b1);
    tick();
    idle(16'd5);
    tick();
    tick();
    chk("amid.pend", bus.pend, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.pend", bus.pend, 0);
    chk("arst.vec", bus.err_vec, 0);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'b0100, '0, 16'd5, 1'b0);
    tick();
    chk("arst.first", bus.pend, 4'b0100);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 16'd5, 1'b0);
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      acc = acc | bus.err_vec;
    end
    chk("men.vec", acc, 0);
    chk("men.pend", bus.pend, 0);
    chk("men.cnt", bus.err_cnt, 0);
    chk("men.sticky", bus.err_sticky, 0);

    // ---- random traffic against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      bus.nukeint  = ($urandom_range(0, 2) == 0);
      bus.resumint = ($urandom_range(0, 7) == 0);
      bus.rstint   = ($urandom_range(0, 9) == 0);
      bus.rstthr   = ($urandom_range(0, 7) == 0) ?
                     '0 : N'($urandom);
      for (int i = 0; i < N; i++) begin
        bus.thr_dead[i] = ($urandom_range(0, 3) == 0);
      end
      bus.max_wait = W'($urandom_range(0, 6));
      bus.mon_en   = ($urandom_range(0, 7) != 0);
      rst          = ($urandom_range(0, 199) == 0);
      tick();
      chk_model("rnd");
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
